// File: rtl/iq_demod_pkg.sv
// Shared definitions for the fs/4 IQ demodulator: LO table, phase type and
// a width-generic saturation helper.
package iq_demod_pkg;

  typedef logic [1:0]        phase_t;
  typedef logic signed [1:0] lo_t;

  localparam lo_t LO_COS [4] = '{2'sb01, 2'sb00, 2'sb11, 2'sb00};
  localparam lo_t LO_SIN [4] = '{2'sb00, 2'sb01, 2'sb00, 2'sb11};

  // Clamp a sign-extended value into the signed range of ow bits.
  function automatic logic signed [31:0] saturate(input logic signed [31:0] x,
                                                  input int unsigned ow);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (ow - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (ow - 1));
    if (x > hi)      saturate = hi;
    else if (x < lo) saturate = lo;
    else             saturate = x;
  endfunction

endpackage

// File: rtl/iq_lo_gen.sv
// fs/4 local oscillator: 2-bit phase counter advanced per accepted sample,
// with synchronous restart and direction-adjusted sin/cos outputs.
module iq_lo_gen
  import iq_demod_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic adv_i,
  input  logic clr_i,
  input  logic dir_i,
  output lo_t  cos_o,
  output lo_t  sin_o
);

  phase_t p_q;
  phase_t p_d;

  always_comb begin
    p_d = p_q;
    if (clr_i)      p_d = '0;
    else if (adv_i) p_d = p_q + 2'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) p_q <= '0;
    else       p_q <= p_d;
  end

  assign cos_o = LO_COS[p_q];
  assign sin_o = dir_i ? -LO_SIN[p_q] : LO_SIN[p_q];

endmodule

// File: rtl/iq_demod_nco.sv
// fs/4 IQ demodulator: multiplier-free mixer, optional 2:1 averaging
// decimator and output saturation with a sticky saturation flag.
module iq_demod_nco
  import iq_demod_pkg::*;
#(
  parameter int DW    = 5,
  parameter int OW    = 5,
  parameter int DECIM = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ADC_rdy,
  input  logic signed [DW-1:0] I_IF,
  input  logic signed [DW-1:0] Q_IF,
  input  logic                 lo_dir,
  input  logic                 phase_clr,
  output logic signed [OW-1:0] I_BB,
  output logic signed [OW-1:0] Q_BB,
  output logic                 demod_rdy,
  output logic                 sat_flag
);

  localparam int MW = DW + 1;
  localparam int SW = DW + 2;

  lo_t  cos_w;
  lo_t  sin_w;
  logic accept;

  assign accept = ADC_rdy & ~phase_clr;

  iq_lo_gen u_lo (
    .clk_i (clk),
    .rst_i (reset),
    .adv_i (accept),
    .clr_i (phase_clr),
    .dir_i (lo_dir),
    .cos_o (cos_w),
    .sin_o (sin_w)
  );

  // Multiply by +1/0/-1; the extra bit keeps -(-2^(DW-1)) exact.
  function automatic logic signed [MW-1:0] scale(input logic signed [DW-1:0] x,
                                                 input lo_t c);
    case (c)
      2'sb01:  scale = MW'(x);
      2'sb11:  scale = -MW'(x);
      default: scale = '0;
    endcase
  endfunction

  logic                 v1_q;
  logic signed [MW-1:0] ii_q, qi_q;
  logic                 have_q, have_d;
  logic signed [MW-1:0] ai_q, ai_d, aq_q, aq_d;
  logic signed [OW-1:0] ibb_q, ibb_d, qbb_q, qbb_d;
  logic                 rdy_q, rdy_d;
  logic                 satf_q, satf_d;

  logic signed [SW-1:0] sum_i, sum_q;
  logic signed [31:0]   pre_i, pre_q, res_i, res_q;
  logic                 clamp;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1_q <= 1'b0;
      ii_q <= '0;
      qi_q <= '0;
    end else begin
      v1_q <= accept;
      if (accept) begin
        ii_q <= scale(I_IF, cos_w) - scale(Q_IF, sin_w);
        qi_q <= scale(I_IF, sin_w) + scale(Q_IF, cos_w);
      end
    end
  end

  always_comb begin
    sum_i = SW'(ai_q) + SW'(ii_q);
    sum_q = SW'(aq_q) + SW'(qi_q);
    if (DECIM == 2) begin
      pre_i = 32'(sum_i >>> 1);
      pre_q = 32'(sum_q >>> 1);
    end else begin
      pre_i = 32'(ii_q);
      pre_q = 32'(qi_q);
    end
    res_i = saturate(pre_i, OW);
    res_q = saturate(pre_q, OW);
    clamp = (res_i != pre_i) | (res_q != pre_q);
  end

  always_comb begin
    have_d = have_q;
    ai_d   = ai_q;
    aq_d   = aq_q;
    ibb_d  = ibb_q;
    qbb_d  = qbb_q;
    rdy_d  = 1'b0;
    satf_d = satf_q;
    if (phase_clr) begin
      have_d = 1'b0;
      satf_d = 1'b0;
    end else if (v1_q) begin
      if ((DECIM == 2) && !have_q) begin
        have_d = 1'b1;
        ai_d   = ii_q;
        aq_d   = qi_q;
      end else begin
        have_d = 1'b0;
        rdy_d  = 1'b1;
        ibb_d  = res_i[OW-1:0];
        qbb_d  = res_q[OW-1:0];
        satf_d = satf_q | clamp;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      have_q <= 1'b0;
      ai_q   <= '0;
      aq_q   <= '0;
      ibb_q  <= '0;
      qbb_q  <= '0;
      rdy_q  <= 1'b0;
      satf_q <= 1'b0;
    end else begin
      have_q <= have_d;
      ai_q   <= ai_d;
      aq_q   <= aq_d;
      ibb_q  <= ibb_d;
      qbb_q  <= qbb_d;
      rdy_q  <= rdy_d;
      satf_q <= satf_d;
    end
  end

  assign I_BB      = ibb_q;
  assign Q_BB      = qbb_q;
  assign demod_rdy = rdy_q;
  assign sat_flag  = satf_q;

endmodule
